// File: rtl/bitseq_capture.sv
// Step-quantised gate recorder: samples gate_in once per step of len cycles and
// packs each DEPTH-step frame into a pattern, first step in the MSB.
module bitseq_capture #(
  parameter int DEPTH = 4,
  localparam int SW = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [23:0]      len,
  input  logic             arm,
  input  logic             cont,
  input  logic             gate_in,
  output logic [DEPTH-1:0] pattern,
  output logic             valid,
  output logic             busy,
  output logic [SW-1:0]    step_idx
);

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  state_t           state_r;
  logic [23:0]      counter_r;
  logic             hit_r;
  logic [DEPTH-1:0] shreg_r;

  logic [23:0]      len_m1_s;
  logic             step_bit_s;
  logic             step_end_s;
  logic             last_step_s;

  // Step boundary decode; >= lets a shortened len close the step at once.
  always_comb begin
    len_m1_s    = (len == 24'd0) ? 24'd0 : (len - 24'd1);
    step_bit_s  = hit_r | gate_in;
    step_end_s  = (counter_r >= len_m1_s);
    last_step_s = (step_idx == SW'(DEPTH - 1));
  end

  // Capture FSM with registered pattern/valid/busy/step_idx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      counter_r <= 24'd0;
      hit_r     <= 1'b0;
      shreg_r   <= {DEPTH{1'b0}};
      step_idx  <= {SW{1'b0}};
      pattern   <= {DEPTH{1'b0}};
      valid     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (ena) begin
        case (state_r)
          IDLE: begin
            counter_r <= 24'd0;
            hit_r     <= 1'b0;
            step_idx  <= {SW{1'b0}};
            if (arm) begin
              state_r <= CAPTURE;
              busy    <= 1'b1;
              shreg_r <= {DEPTH{1'b0}};
            end else begin
              state_r <= IDLE;
              busy    <= 1'b0;
            end
          end
          CAPTURE: begin
            if (arm) begin
              // Restart wins over any boundary in the same cycle.
              counter_r <= 24'd0;
              hit_r     <= 1'b0;
              step_idx  <= {SW{1'b0}};
              shreg_r   <= {DEPTH{1'b0}};
              busy      <= 1'b1;
            end else if (step_end_s) begin
              counter_r <= 24'd0;
              hit_r     <= 1'b0;
              if (last_step_s) begin
                pattern  <= {shreg_r[DEPTH-2:0], step_bit_s};
                valid    <= 1'b1;
                step_idx <= {SW{1'b0}};
                shreg_r  <= {DEPTH{1'b0}};
                if (cont) begin
                  state_r <= CAPTURE;
                  busy    <= 1'b1;
                end else begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
                end
              end else begin
                shreg_r  <= {shreg_r[DEPTH-2:0], step_bit_s};
                step_idx <= step_idx + SW'(1'b1);
              end
            end else begin
              counter_r <= counter_r + 24'd1;
              hit_r     <= step_bit_s;
            end
          end
          default: begin
            state_r   <= IDLE;
            busy      <= 1'b0;
            counter_r <= 24'd0;
            hit_r     <= 1'b0;
            step_idx  <= {SW{1'b0}};
            shreg_r   <= {DEPTH{1'b0}};
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule

// File: tb/tb_bitseq_capture.sv
// Bench for bitseq_capture: directed scenarios plus randomized traffic, all
// checked every cycle against a step-list reference model.
module tb_bitseq_capture;
  localparam int DEPTH = 4;
  localparam int SW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ena;
  logic [23:0]      len;
  logic             arm;
  logic             cont;
  logic             gate_in;
  logic [DEPTH-1:0] pattern;
  logic             valid;
  logic             busy;
  logic [SW-1:0]    step_idx;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: elapsed cycles in the step, OR of the step, finished step bits.
  int               m_cap;
  int               m_elapsed;
  int               m_hit;
  int               m_bits[$];
  logic [DEPTH-1:0] m_pat;
  int               m_valid;

  bitseq_capture #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .len(len), .arm(arm), .cont(cont),
    .gate_in(gate_in), .pattern(pattern), .valid(valid), .busy(busy),
    .step_idx(step_idx)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cap = 0; m_elapsed = 0; m_hit = 0; m_bits.delete(); m_pat = '0; m_valid = 0;
  endtask

  task automatic model_step();
    int l;
    m_valid = 0;
    if (!rst_n) begin
      model_reset();
    end else if (ena) begin
      l = (len == 24'd0) ? 1 : int'(len);
      if (arm) begin
        m_cap = 1; m_elapsed = 0; m_hit = 0; m_bits.delete();
      end else if (m_cap != 0) begin
        m_hit = m_hit | int'(gate_in);
        m_elapsed++;
        if (m_elapsed >= l) begin
          m_bits.push_back(m_hit);
          m_elapsed = 0; m_hit = 0;
          if (m_bits.size() == DEPTH) begin
            m_pat = '0;
            foreach (m_bits[i]) m_pat = DEPTH'((int'(m_pat) * 2) + m_bits[i]);
            m_valid = 1;
            m_bits.delete();
            m_cap = int'(cont);
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    check_eq("valid", 32'(valid), 32'(m_valid));
    check_eq("busy", 32'(busy), 32'(m_cap));
    check_eq("pattern", 32'(pattern), 32'(m_pat));
    check_eq("step_idx", 32'(step_idx), (m_cap != 0) ? 32'(m_bits.size()) : 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  initial begin
    int vcnt;
    int vpos;
    logic [DEPTH-1:0] first_pat;
    logic [3:0] seqv;
    logic [DEPTH-1:0] pat_prev;

    rst_n = 1'b0; ena = 1'b1; len = 24'd4; arm = 1'b0; cont = 1'b0; gate_in = 1'b0;
    model_reset();
    tick(); tick();
    check_eq("reset_pattern", 32'(pattern), 32'd0);
    check_eq("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic capture: pulses in cycle 2 of step 0 and last cycle of step 2.
    do_arm();
    vpos = 0;
    for (int n = 1; n <= 16; n++) begin
      gate_in = (n == 2 || n == 12);
      tick();
      if (valid === 1'b1 && vpos == 0) vpos = n;
    end
    gate_in = 1'b0;
    check_eq("basic_latency", 32'(vpos), 32'd16);
    check_eq("basic_pattern", 32'(pattern), 32'b1010);
    tick();
    check_eq("basic_idle", 32'(busy), 32'd0);

    // len 0 and len 1: one step per cycle.
    for (int lv = 0; lv < 2; lv++) begin
      len = 24'(lv);
      do_arm();
      for (int n = 1; n <= 4; n++) begin
        gate_in = n[0];
        tick();
      end
      gate_in = 1'b0;
      check_eq("len01_valid", 32'(valid), 32'd1);
      check_eq("len01_pattern", 32'(pattern), 32'b1010);
      tick();
    end

    // ena gating: freeze mid-step with gate high; frame ends 7 cycles late.
    len = 24'd3;
    do_arm();
    vpos = 0;
    for (int n = 1; n <= 4; n++) begin
      gate_in = 1'b0; tick();
    end
    ena = 1'b0; gate_in = 1'b1;
    for (int n = 0; n < 7; n++) begin
      tick();
      check_eq("ena_low_valid", 32'(valid), 32'd0);
      check_eq("ena_low_step", 32'(step_idx), 32'd1);
    end
    ena = 1'b1; gate_in = 1'b0;
    for (int n = 12; n <= 40 && vpos == 0; n++) begin
      tick();
      if (valid === 1'b1) vpos = n;
    end
    check_eq("ena_latency", 32'(vpos), 32'd19);
    check_eq("ena_pattern", 32'(pattern), 32'b0000);

    // Re-arm mid-frame and on the frame-end cycle.
    len = 24'd2;
    gate_in = 1'b1;
    do_arm();
    for (int n = 1; n <= 5; n++) tick();
    pat_prev = pattern;
    do_arm();
    check_eq("rearm_valid", 32'(valid), 32'd0);
    check_eq("rearm_step", 32'(step_idx), 32'd0);
    check_eq("rearm_pattern", 32'(pattern), 32'(pat_prev));
    for (int n = 1; n <= 7; n++) tick();
    do_arm();
    check_eq("coinc_valid", 32'(valid), 32'd0);
    check_eq("coinc_pattern", 32'(pattern), 32'(pat_prev));
    check_eq("coinc_busy", 32'(busy), 32'd1);
    for (int n = 1; n <= 8; n++) tick();
    check_eq("after_coinc_pattern", 32'(pattern), 32'b1111);

    // Loopback from an emulated sequencer (len=5, seq=1101), continuous mode.
    len = 24'd5; cont = 1'b1; seqv = 4'b1101; vcnt = 0; first_pat = '0;
    gate_in = 1'b0;
    do_arm();
    for (int n = 1; n <= 80; n++) begin
      gate_in = seqv[3 - (((n - 1) / 5) % 4)];
      tick();
      if (valid === 1'b1) begin
        vcnt++;
        check_eq("loop_period", 32'(n % 20), 32'd0);
        if (vcnt == 1) first_pat = pattern;
        check_eq("loop_const", 32'(pattern), 32'(first_pat));
        check_eq("loop_pattern", 32'(pattern), 32'(seqv));
      end
    end
    check_eq("loop_count", 32'(vcnt), 32'd4);
    cont = 1'b0; gate_in = 1'b0;
    for (int n = 0; n < 22; n++) tick();

    // Async reset during step 2, between clock edges.
    len = 24'd4;
    do_arm();
    for (int n = 1; n <= 9; n++) tick();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("arst_pattern", 32'(pattern), 32'd0);
    check_eq("arst_valid", 32'(valid), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_step", 32'(step_idx), 32'd0);
    #2;
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      gate_in = 1'($urandom_range(1));
      tick();
      check_eq("arst_idle", 32'(busy), 32'd0);
    end

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      ena     = ($urandom_range(99) < 85);
      arm     = ($urandom_range(99) < 3);
      gate_in = 1'($urandom_range(1));
      if ($urandom_range(15) == 0) len = 24'($urandom_range(4));
      if ($urandom_range(31) == 0) cont = 1'($urandom_range(1));
      tick();
    end
    arm = 1'b0; ena = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
